// File: rtl/student_fir_out_quantizer_pkg.sv
// -----------------------------------------------------------------------------
// student_fir_out_quantizer_pkg
//
// Shared constants and helpers for the FIR output quantizer and its
// neighbours in the audio path.
//   - DEF_* : default widths/depths used as parameter defaults
//   - sat_kind_e : classification of a stage-1 value against the output range
//   - sat_max / sat_min : largest / smallest signed value of a given width
// -----------------------------------------------------------------------------
package student_fir_out_quantizer_pkg;

    localparam int unsigned DEF_IN_WIDTH    = 33;
    localparam int unsigned DEF_OUT_WIDTH   = 16;
    localparam int unsigned DEF_SHIFT_WIDTH = 6;
    localparam int unsigned DEF_FIFO_DEPTH  = 4;
    localparam int unsigned DEF_CNT_WIDTH   = 16;

    typedef enum logic [1:0] {
        SAT_NONE = 2'b00,
        SAT_HIGH = 2'b01,
        SAT_LOW  = 2'b10
    } sat_kind_e;

    // Largest signed value representable in 'width' bits.
    function automatic longint sat_max(input int unsigned width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    // Smallest signed value representable in 'width' bits.
    function automatic longint sat_min(input int unsigned width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/student_sync_fifo.sv
// -----------------------------------------------------------------------------
// student_sync_fifo
//
// Single-clock FIFO with registered storage and no write-to-read bypass.
// Pointers carry one extra bit so full/empty are distinguished and the
// occupancy is simply the pointer difference.
//
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (empties the FIFO, clears storage)
//   push   : write request; ignored when full unless a pop happens this cycle
//   wdata  : write data
//   pop    : read request; ignored when empty
//   rdata  : head entry (valid while !empty)
//   full   : DEPTH entries stored
//   empty  : no entries stored
//   level  : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module student_sync_fifo #(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == (AW + 1)'(DEPTH));
    assign empty = (level == '0);
    assign rdata = mem[rd_ptr[AW-1:0]];

    // A push into a full FIFO is accepted only when the head leaves in the
    // same cycle; the freed slot is the one the write pointer targets.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/student_fir_out_quantizer.sv
// -----------------------------------------------------------------------------
// student_fir_out_quantizer
//
// Converts the wide FIR adder-tree sum into a signed OUT_WIDTH sample:
// arithmetic right shift with round-half-up, then saturate (or wrap), then
// buffer in a small FIFO read out over ready/valid.
//
// Ports:
//   clk_i           : clock
//   rst_i           : synchronous active-high reset, discards all samples
//   valid_strobe_in : y_in valid this cycle (one sample per high cycle)
//   y_in            : signed FIR sum
//   shift_i         : right-shift amount, sampled with valid_strobe_in
//   sat_en_i        : 1 = saturate, 0 = keep OUT_WIDTH LSBs (sampled at stage 2)
//   clear_i         : clears overflow_o and both counters
//   sample_out      : FIFO head sample
//   valid_out       : sample_out valid
//   ready_in        : consumer accepts when valid_out && ready_in
//   overflow_o      : sticky, a sample was dropped at a full FIFO
//   sat_count_o     : saturated sample count (saturating)
//   drop_count_o    : dropped sample count (saturating)
//   fifo_level_o    : FIFO occupancy
// -----------------------------------------------------------------------------
module student_fir_out_quantizer
    import student_fir_out_quantizer_pkg::*;
#(
    parameter int unsigned IN_WIDTH    = DEF_IN_WIDTH,
    parameter int unsigned OUT_WIDTH   = DEF_OUT_WIDTH,
    parameter int unsigned SHIFT_WIDTH = DEF_SHIFT_WIDTH,
    parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          valid_strobe_in,
    input  logic signed [IN_WIDTH-1:0]    y_in,
    input  logic [SHIFT_WIDTH-1:0]        shift_i,
    input  logic                          sat_en_i,
    input  logic                          clear_i,
    output logic [OUT_WIDTH-1:0]          sample_out,
    output logic                          valid_out,
    input  logic                          ready_in,
    output logic                          overflow_o,
    output logic [CNT_WIDTH-1:0]          sat_count_o,
    output logic [CNT_WIDTH-1:0]          drop_count_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int unsigned EFF_W = $clog2(IN_WIDTH);

    // Output range expressed in the stage-1 width for the range compare.
    localparam logic signed [IN_WIDTH:0]  T_MAX   = (IN_WIDTH + 1)'(sat_max(OUT_WIDTH));
    localparam logic signed [IN_WIDTH:0]  T_MIN   = (IN_WIDTH + 1)'(sat_min(OUT_WIDTH));
    localparam logic [OUT_WIDTH-1:0]      OUT_MAX = OUT_WIDTH'(sat_max(OUT_WIDTH));
    localparam logic [OUT_WIDTH-1:0]      OUT_MIN = OUT_WIDTH'(sat_min(OUT_WIDTH));

    // ---------------- stage 1: shift with round-half-up ----------------
    logic [EFF_W-1:0]        eff_shift;
    logic signed [IN_WIDTH:0] y_ext;
    logic signed [IN_WIDTH:0] rnd;
    logic signed [IN_WIDTH:0] rnd_sum;
    logic signed [IN_WIDTH:0] t_next;

    logic                     s1_valid;
    logic signed [IN_WIDTH:0] s1_t;

    always_comb begin
        if (32'(shift_i) > IN_WIDTH - 1) begin
            eff_shift = EFF_W'(IN_WIDTH - 1);
        end else begin
            eff_shift = EFF_W'(shift_i);
        end

        // One guard bit keeps the rounding add from overflowing.
        y_ext   = {y_in[IN_WIDTH-1], y_in};
        rnd     = '0;
        rnd_sum = y_ext;
        t_next  = y_ext;
        if (eff_shift != '0) begin
            rnd     = (IN_WIDTH + 1)'(1) << (eff_shift - EFF_W'(1));
            rnd_sum = y_ext + rnd;
            t_next  = rnd_sum >>> eff_shift;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_t     <= '0;
        end else begin
            s1_valid <= valid_strobe_in;
            if (valid_strobe_in) begin
                s1_t <= t_next;
            end
        end
    end

    // ---------------- stage 2: range check and saturate/wrap ----------------
    sat_kind_e              sat_kind;
    logic [OUT_WIDTH-1:0]   s2_next;
    logic                   sat_evt;

    logic                   s2_valid;
    logic [OUT_WIDTH-1:0]   s2_data;

    always_comb begin
        sat_kind = SAT_NONE;
        if (s1_t > T_MAX) begin
            sat_kind = SAT_HIGH;
        end else if (s1_t < T_MIN) begin
            sat_kind = SAT_LOW;
        end

        s2_next = s1_t[OUT_WIDTH-1:0];
        sat_evt = 1'b0;
        if (sat_en_i) begin
            case (sat_kind)
                SAT_HIGH: begin
                    s2_next = OUT_MAX;
                    sat_evt = s1_valid;
                end
                SAT_LOW: begin
                    s2_next = OUT_MIN;
                    sat_evt = s1_valid;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= s2_next;
            end
        end
    end

    // ---------------- output FIFO ----------------
    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic drop_evt;

    assign valid_out = !fifo_empty;
    assign pop       = valid_out && ready_in;
    assign drop_evt  = s2_valid && fifo_full && !pop;

    student_sync_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (s2_valid),
        .wdata (s2_data),
        .pop   (pop),
        .rdata (sample_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level_o)
    );

    // ---------------- status: sticky flag and saturating counters ----------------
    // clear_i takes priority, so an event in the clear cycle is discarded.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            overflow_o   <= 1'b0;
            sat_count_o  <= '0;
            drop_count_o <= '0;
        end else begin
            if (drop_evt) begin
                overflow_o <= 1'b1;
                if (drop_count_o != '1) begin
                    drop_count_o <= drop_count_o + 1'b1;
                end
            end
            if (sat_evt && (sat_count_o != '1)) begin
                sat_count_o <= sat_count_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_student_fir_out_quantizer.sv
// -----------------------------------------------------------------------------
// tb_student_fir_out_quantizer
//
// Directed self-checking bench for student_fir_out_quantizer. Inputs change
// 1 time unit after each rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_student_fir_out_quantizer;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic               valid_strobe_in = 1'b0;
    logic signed [32:0] y_in = '0;
    logic [5:0]         shift_i = '0;
    logic               sat_en_i = 1'b1;
    logic               clear_i = 1'b0;
    logic [15:0]        sample_out;
    logic               valid_out;
    logic               ready_in = 1'b1;
    logic               overflow_o;
    logic [15:0]        sat_count_o;
    logic [15:0]        drop_count_o;
    logic [2:0]         fifo_level_o;

    int n_cmp = 0;
    int n_err = 0;

    logic signed [32:0] rvec [4] = '{33'sd32768, 33'sd16384, -33'sd16384, -33'sd16385};
    logic [15:0]        rexp [4] = '{16'h0001, 16'h0001, 16'h0000, 16'hFFFF};

    student_fir_out_quantizer #(
        .IN_WIDTH    (33),
        .OUT_WIDTH   (16),
        .SHIFT_WIDTH (6),
        .FIFO_DEPTH  (4),
        .CNT_WIDTH   (16)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .valid_strobe_in (valid_strobe_in),
        .y_in            (y_in),
        .shift_i         (shift_i),
        .sat_en_i        (sat_en_i),
        .clear_i         (clear_i),
        .sample_out      (sample_out),
        .valid_out       (valid_out),
        .ready_in        (ready_in),
        .overflow_o      (overflow_o),
        .sat_count_o     (sat_count_o),
        .drop_count_o    (drop_count_o),
        .fifo_level_o    (fifo_level_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One-cycle strobe; returns one cycle after the strobe cycle.
    task automatic send(input logic signed [32:0] v, input logic [5:0] sh);
        valid_strobe_in = 1'b1;
        y_in            = v;
        shift_i         = sh;
        tick();
        valid_strobe_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        n_cmp++;
        if (valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: got %b expected 0", valid_out);
        end
        n_cmp++;
        if (sample_out !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_sample: got %h expected 0000", sample_out);
        end
        n_cmp++;
        if ({overflow_o, sat_count_o, drop_count_o, fifo_level_o} !== '0) begin
            n_err++;
            $display("FAIL reset_status: got ovf=%b sat=%0d drop=%0d lvl=%0d expected all 0",
                     overflow_o, sat_count_o, drop_count_o, fifo_level_o);
        end
    endtask

    task automatic test_latency_rounding();
        ready_in = 1'b1;
        sat_en_i = 1'b1;
        // Latency: strobe in cycle N, valid_out first high in N+3.
        send(rvec[0], 6'd15);
        n_cmp++;
        if (valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL latency_n1: got valid %b expected 0", valid_out);
        end
        tick();
        n_cmp++;
        if (valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL latency_n2: got valid %b expected 0", valid_out);
        end
        tick();
        n_cmp++;
        if (valid_out !== 1'b1 || sample_out !== rexp[0]) begin
            n_err++;
            $display("FAIL latency_n3: got valid %b sample %h expected 1 %h",
                     valid_out, sample_out, rexp[0]);
        end
        tick();
        for (int i = 1; i < 4; i++) begin
            send(rvec[i], 6'd15);
            tick();
            tick();
            n_cmp++;
            if (valid_out !== 1'b1 || sample_out !== rexp[i]) begin
                n_err++;
                $display("FAIL round_%0d: got valid %b sample %h expected 1 %h",
                         i, valid_out, sample_out, rexp[i]);
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        sat_en_i = 1'b1;
        send(33'sd2147483647, 6'd15);
        tick();
        tick();
        n_cmp++;
        if (sample_out !== 16'h7FFF || sat_count_o !== 16'd1) begin
            n_err++;
            $display("FAIL sat_pos: got %h cnt %0d expected 7fff cnt 1", sample_out, sat_count_o);
        end
        tick();
        send(-33'sd2147483648, 6'd15);
        tick();
        tick();
        n_cmp++;
        if (sample_out !== 16'h8000 || sat_count_o !== 16'd2) begin
            n_err++;
            $display("FAIL sat_neg: got %h cnt %0d expected 8000 cnt 2", sample_out, sat_count_o);
        end
        tick();
        // Wrap mode: 2^31-1 rounds to t=65536, whose 16 LSBs are 0.
        sat_en_i = 1'b0;
        send(33'sd2147483647, 6'd15);
        tick();
        tick();
        n_cmp++;
        if (sample_out !== 16'h0000 || sat_count_o !== 16'd2) begin
            n_err++;
            $display("FAIL wrap_65536: got %h cnt %0d expected 0000 cnt 2", sample_out, sat_count_o);
        end
        tick();
        // 65535 * 2^15 gives t=65535, which wraps to 0xFFFF.
        send(33'sd2147450880, 6'd15);
        tick();
        tick();
        n_cmp++;
        if (sample_out !== 16'hFFFF || sat_count_o !== 16'd2) begin
            n_err++;
            $display("FAIL wrap_65535: got %h cnt %0d expected ffff cnt 2", sample_out, sat_count_o);
        end
        tick();
        sat_en_i = 1'b1;
    endtask

    task automatic test_shift_clamp();
        send(33'sd4294967295, 6'd63);
        tick();
        tick();
        n_cmp++;
        if (valid_out !== 1'b1 || sample_out !== 16'h0001) begin
            n_err++;
            $display("FAIL shift_clamp: got valid %b sample %h expected 1 0001", valid_out, sample_out);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_v;
        ready_in = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send(33'(i), 6'd0);
        end
        tick();
        tick();
        tick();
        n_cmp++;
        if (fifo_level_o !== 3'd4 || overflow_o !== 1'b1 || drop_count_o !== 16'd1) begin
            n_err++;
            $display("FAIL bp_fill: got lvl %0d ovf %b drop %0d expected 4 1 1",
                     fifo_level_o, overflow_o, drop_count_o);
        end
        ready_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            exp_v = 16'(i);
            n_cmp++;
            if (valid_out !== 1'b1 || sample_out !== exp_v) begin
                n_err++;
                $display("FAIL bp_drain_%0d: got valid %b sample %h expected 1 %h",
                         i, valid_out, sample_out, exp_v);
            end
            tick();
        end
        n_cmp++;
        if (valid_out !== 1'b0 || fifo_level_o !== 3'd0) begin
            n_err++;
            $display("FAIL bp_empty: got valid %b lvl %0d expected 0 0", valid_out, fifo_level_o);
        end
    endtask

    task automatic test_full_push_pop();
        ready_in = 1'b0;
        for (int i = 10; i <= 13; i++) begin
            send(33'(i), 6'd0);
        end
        tick();
        tick();
        tick();
        n_cmp++;
        if (fifo_level_o !== 3'd4 || drop_count_o !== 16'd1) begin
            n_err++;
            $display("FAIL full_refill: got lvl %0d drop %0d expected 4 1", fifo_level_o, drop_count_o);
        end
        // Strobe in cycle M; its push lands at the end of M+2, so pop then.
        send(33'sd14, 6'd0);
        tick();
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        n_cmp++;
        if (fifo_level_o !== 3'd4 || drop_count_o !== 16'd1 || sample_out !== 16'd11) begin
            n_err++;
            $display("FAIL full_push_pop: got lvl %0d drop %0d head %0d expected 4 1 11",
                     fifo_level_o, drop_count_o, sample_out);
        end
    endtask

    task automatic test_clear();
        logic [15:0] exp_v;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        n_cmp++;
        if (overflow_o !== 1'b0 || sat_count_o !== 16'd0 || drop_count_o !== 16'd0) begin
            n_err++;
            $display("FAIL clear_status: got ovf %b sat %0d drop %0d expected 0 0 0",
                     overflow_o, sat_count_o, drop_count_o);
        end
        n_cmp++;
        if (fifo_level_o !== 3'd4) begin
            n_err++;
            $display("FAIL clear_level: got %0d expected 4", fifo_level_o);
        end
        ready_in = 1'b1;
        for (int i = 11; i <= 14; i++) begin
            exp_v = 16'(i);
            n_cmp++;
            if (valid_out !== 1'b1 || sample_out !== exp_v) begin
                n_err++;
                $display("FAIL clear_drain_%0d: got valid %b sample %0d expected 1 %0d",
                         i, valid_out, sample_out, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        ready_in = 1'b0;
        for (int i = 21; i <= 24; i++) begin
            send(33'(i), 6'd0);
        end
        tick();
        n_cmp++;
        if (fifo_level_o !== 3'd3) begin
            n_err++;
            $display("FAIL midrst_pre: got lvl %0d expected 3", fifo_level_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        n_cmp++;
        if (fifo_level_o !== 3'd0 || valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_post: got lvl %0d valid %b expected 0 0", fifo_level_o, valid_out);
        end
        tick();
        tick();
        tick();
        n_cmp++;
        if (fifo_level_o !== 3'd0 || valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_inflight: got lvl %0d valid %b expected 0 0", fifo_level_o, valid_out);
        end
    endtask

    initial begin
        test_reset();
        test_latency_rounding();
        test_saturation();
        test_shift_clamp();
        test_backpressure();
        test_full_push_pop();
        test_clear();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
